axba_line_compressor: RTL
=========================

# axba_line_compressor

Parametrised, handshaked successor to the fixed 8×32-bit AxBA compressor. It accepts one cache line of NUM_WORDS words and scans it one word per cycle against a base word (word 0) and a runtime error margin. Each line is emitted either as base + approximate-flag mask + narrow signed deltas, or as uncompressible raw. It sits between the line buffer and the approximate-transfer link, upstream of the AxBA decompressor.

## Interface
- WORD_W, 32, word width in bits (≥ DELTA_W+1)
- NUM_WORDS, 8, words per line (≥ 2)
- DELTA_W, 8, signed delta field width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  line offered
- in_ready  out  1  line accepted when in_valid && in_ready
- in_data  in  NUM_WORDS*WORD_W  word i = in_data[i*WORD_W +: WORD_W]
- error_margin  in  WORD_W  unsigned approximation margin, sampled at accept
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_compressed  out  1  1 = base/delta encoding valid; 0 = raw
- out_base  out  WORD_W  captured word 0
- out_deltas  out  NUM_WORDS*DELTA_W  delta i at [i*DELTA_W +: DELTA_W]
- out_approx_mask  out  NUM_WORDS  bit i = word i replaced by base
- out_raw  out  NUM_WORDS*WORD_W  captured line (always)
- out_size  out  $clog2(NUM_WORDS*WORD_W+1)  payload bits
- stat_lines  out  32  lines emitted, saturating
- stat_compressed  out  32  compressed lines emitted, saturating

## Operation
- FSM: IDLE → SCAN → EMIT → IDLE.
- IDLE: in_ready=1. On accept: capture in_data, error_margin; base = word 0; idx=0; go SCAN.
- SCAN: one word per cycle, idx 0..NUM_WORDS-1. delta = word − base mod 2^WORD_W, interpreted signed.
  - |delta| ≤ margin (unsigned compare; magnitude of most-negative value is 2^(WORD_W-1)): mask bit 1, delta field 0.
  - else if −2^(DELTA_W-1) ≤ delta ≤ 2^(DELTA_W-1)−1: mask bit 0, delta field = delta[DELTA_W-1:0].
  - else: abort. out_compressed=0; mask and deltas forced 0; go EMIT next cycle.
  - Word 0 always gives mask 1, delta 0.
  - After idx = NUM_WORDS-1 with no abort: out_compressed=1; go EMIT.
- out_size: compressed = WORD_W + NUM_WORDS + NUM_WORDS*DELTA_W; raw = NUM_WORDS*WORD_W.
- EMIT: out_valid=1. All out_* held stable until out_ready. On handshake: increment stat_lines, plus stat_compressed if compressed (each saturates at 2^32−1); go IDLE.
- Single line in flight; in_ready=0 in SCAN and EMIT. error_margin changes after accept are ignored.

## Timing
- Reset (any state, including mid-scan or during EMIT): next edge goes to IDLE and discards the line. All outputs 0, stat counters 0. in_ready is 0 while reset is high, then 1.
- Accept at edge T. Word k is evaluated at cycle T+1+k.
- No abort: out_valid from T+NUM_WORDS+1.
- Abort at word k (k ≥ 1): out_valid from T+k+2. Earliest is T+3.
- Handshake at edge E: out_valid=0 and in_ready=1 from E+1. The next accept is possible at E+1, so there is one idle cycle per line minimum.
- out_valid never drops without a handshake except on reset.

## Structure
- Package axba_pkg:
  - state enum (IDLE, SCAN, EMIT)
  - function axba_size(compressed, WORD_W, NUM_WORDS, DELTA_W)
  - saturating-increment function
- Sub-module axba_word_classifier (combinational): base, word, margin → approx, fits, delta. Parametrised by WORD_W and DELTA_W.
- Top module holds the FSM, capture registers, index counter, output registers and stats.

## Test plan
Defaults: WORD_W=32, NUM_WORDS=8, DELTA_W=8. Words listed as word 0 … word 7.

- Line {AABBCCDD, AACBCCDE, AABBCCDF, AABBCCD0, AABBCCD1, AABBCCD2, AABBCCD3, AABBCCD4}, margin 0x10 → word 1 delta 0x00100001 aborts. out_valid at T+3, out_compressed=0, out_size=256, mask 0x00.
- Line {AABBCCDD, AABBCCDE, AABBCCDF, AABBCCD0, D1, D2, D3, D4 (same upper bytes)}, margin 0x10 → out_valid at T+9, compressed=1, mask 0xFF, deltas all 0, out_size=104.
- Same line, margin 0 → mask 0x01, deltas word1..7 = 01, 02, F3, F4, F5, F6, F7, compressed=1.
- Width and margin boundaries:
  - base 00000000, word 1 = 0000007F and word 2 = FFFFFF80, margin 0 → fits, deltas 7F and 80.
  - word 1 = 00000080, margin 0 → abort.
  - word 1 = 00000080, margin 0x80 → mask bit 1.
  - base FFFFFFFF, word 1 = 00000000 → delta 01 (wrap-around).
- Backpressure: out_ready low for 5 cycles with in_valid high → outputs stable, in_ready=0, no second accept. Handshake then gives stat_lines+1, and the next line is accepted the following cycle.
- Reset asserted at T+4 mid-scan → out_valid never asserts, stats 0, in_ready=1 after release. A subsequent line is processed with normal latency.

Source files
------------

// File: rtl/axba_pkg.sv
// axba_pkg: shared FSM state type, payload-size and saturating-counter helpers for the AxBA compressor
package axba_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
    function automatic int axba_size(input logic compressed, input int word_w, input int num_words, input int delta_w);
        return compressed ? word_w + num_words + num_words * delta_w : num_words * word_w;
    endfunction
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/axba_word_classifier.sv
// axba_word_classifier: decides whether a word is approximable by the base or fits a narrow signed delta
module axba_word_classifier #(
    parameter int WORD_W  = 32,
    parameter int DELTA_W = 8
) (
    input  logic [WORD_W-1:0]  base_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic [WORD_W-1:0]  margin_i,
    output logic               approx_o,
    output logic               fits_o,
    output logic [DELTA_W-1:0] delta_o
);
    logic [WORD_W-1:0] diff, mag;
    assign diff     = word_i - base_i;
    // negating the most-negative value leaves 2^(WORD_W-1), the correct unsigned magnitude
    assign mag      = diff[WORD_W-1] ? -diff : diff;
    assign approx_o = mag <= margin_i;
    assign fits_o   = &diff[WORD_W-1:DELTA_W-1] | ~|diff[WORD_W-1:DELTA_W-1];
    assign delta_o  = diff[DELTA_W-1:0];
endmodule

// File: rtl/axba_line_compressor.sv
// axba_line_compressor: handshaked base+delta line compressor scanning one word per cycle
module axba_line_compressor
    import axba_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int DELTA_W   = 8,
    localparam int SW       = $clog2(NUM_WORDS * WORD_W + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_WORDS*WORD_W-1:0]    in_data,
    input  logic [WORD_W-1:0]              error_margin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_compressed,
    output logic [WORD_W-1:0]              out_base,
    output logic [NUM_WORDS*DELTA_W-1:0]   out_deltas,
    output logic [NUM_WORDS-1:0]           out_approx_mask,
    output logic [NUM_WORDS*WORD_W-1:0]    out_raw,
    output logic [SW-1:0]                  out_size,
    output logic [31:0]                    stat_lines,
    output logic [31:0]                    stat_compressed
);
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
    localparam logic [SW-1:0] SIZE_COMP = SW'(axba_size(1'b1, WORD_W, NUM_WORDS, DELTA_W));
    localparam logic [SW-1:0] SIZE_RAW  = SW'(axba_size(1'b0, WORD_W, NUM_WORDS, DELTA_W));

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NUM_WORDS*WORD_W-1:0] line_q, line_d;
    logic [WORD_W-1:0] margin_q, margin_d;
    logic [NUM_WORDS-1:0] mask_q, mask_d;
    logic [NUM_WORDS*DELTA_W-1:0] deltas_q, deltas_d;
    logic comp_q, comp_d;
    logic [SW-1:0] size_q, size_d;
    logic [31:0] lines_q, lines_d, ncomp_q, ncomp_d;
    logic approx, fits;
    logic [DELTA_W-1:0] delta;

    axba_word_classifier #(.WORD_W(WORD_W), .DELTA_W(DELTA_W)) u_cls (
        .base_i   (line_q[WORD_W-1:0]),
        .word_i   (line_q[idx_q*WORD_W +: WORD_W]),
        .margin_i (margin_q),
        .approx_o (approx),
        .fits_o   (fits),
        .delta_o  (delta)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        line_d   = line_q;
        margin_d = margin_q;
        mask_d   = mask_q;
        deltas_d = deltas_q;
        comp_d   = comp_q;
        size_d   = size_q;
        lines_d  = lines_q;
        ncomp_d  = ncomp_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d  = SCAN;
                idx_d    = '0;
                line_d   = in_data;
                margin_d = error_margin;
                mask_d   = '0;
                deltas_d = '0;
                comp_d   = 1'b0;
            end
            SCAN: if (!approx && !fits) begin
                state_d  = EMIT;
                mask_d   = '0;
                deltas_d = '0;
                comp_d   = 1'b0;
                size_d   = SIZE_RAW;
            end else begin
                mask_d[idx_q] = approx;
                deltas_d[idx_q*DELTA_W +: DELTA_W] = approx ? '0 : delta;
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == LAST ? EMIT : SCAN;
                comp_d  = idx_q == LAST;
                size_d  = idx_q == LAST ? SIZE_COMP : size_q;
            end
            EMIT: if (out_ready) begin
                state_d = IDLE;
                lines_d = sat_inc(lines_q);
                ncomp_d = comp_q ? sat_inc(ncomp_q) : ncomp_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            line_q   <= '0;
            margin_q <= '0;
            mask_q   <= '0;
            deltas_q <= '0;
            comp_q   <= 1'b0;
            size_q   <= '0;
            lines_q  <= '0;
            ncomp_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            line_q   <= line_d;
            margin_q <= margin_d;
            mask_q   <= mask_d;
            deltas_q <= deltas_d;
            comp_q   <= comp_d;
            size_q   <= size_d;
            lines_q  <= lines_d;
            ncomp_q  <= ncomp_d;
        end
    end

    assign in_ready        = state_q == IDLE && !reset;
    assign out_valid       = state_q == EMIT;
    assign out_compressed  = comp_q;
    assign out_base        = line_q[WORD_W-1:0];
    assign out_deltas      = deltas_q;
    assign out_approx_mask = mask_q;
    assign out_raw         = line_q;
    assign out_size        = size_q;
    assign stat_lines      = lines_q;
    assign stat_compressed = ncomp_q;
endmodule
